sram_arbiter: RTL and testbench

- Two-client arbiter between the SRAM controller and its two users: the hash/update path (client U) and the memory shifter (client S).
- Each client's single-outstanding, pulse-request read and write channels are merged onto one SRAM read/write request interface.
- Acks are returned to the owning client.
- In-order read data is steered back using an owner-tag FIFO.

---
 rtl/sram_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-client (U = update path, S = shifter) arbiter onto one SRAM read/write port, with an
// owner-tag FIFO steering in-order read data. Define SRAM_ARB_RR_EN for round-robin clients.
module sram_arbiter #(
  parameter int unsigned SRAM_ADDR_WIDTH = 19,
  parameter int unsigned SRAM_DATA_WIDTH = 72,
  parameter int unsigned TAG_DEPTH_BITS  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       upd_rd_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] upd_rd_addr,
  output logic                       upd_rd_ack,
  output logic [SRAM_DATA_WIDTH-1:0] upd_rd_data,
  output logic                       upd_rd_vld,
  input  logic                       upd_wr_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] upd_wr_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] upd_wr_data,
  output logic                       upd_wr_ack,
  input  logic                       shi_rd_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] shi_rd_addr,
  output logic                       shi_rd_ack,
  output logic [SRAM_DATA_WIDTH-1:0] shi_rd_data,
  output logic                       shi_rd_vld,
  input  logic                       shi_wr_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] shi_wr_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] shi_wr_data,
  output logic                       shi_wr_ack,
  output logic                       sram_rd_req,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic                       sram_rd_ack,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
  input  logic                       sram_rd_vld,
  output logic                       sram_wr_req,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
  input  logic                       sram_wr_ack,
  output logic                       arb_err
);

  localparam int unsigned TagDepth = 1 << TAG_DEPTH_BITS;
  localparam int unsigned CntW     = TAG_DEPTH_BITS + 1;
  localparam logic [TAG_DEPTH_BITS-1:0] PtrOne  = 1;
  localparam logic [CntW-1:0]           CntFull = CntW'(TagDepth);

  typedef enum logic [1:0] {StIdle, StWaitRd, StWaitWr} state_e;

  // Channel index: bit 0 = write, bit 1 = client S.
  logic [3:0]                 req_in;
  logic [SRAM_ADDR_WIDTH-1:0] addr_in [4];

  state_e                     state_q, state_d;
  logic [3:0]                 pend_q, pend_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q [4];
  logic [SRAM_ADDR_WIDTH-1:0] addr_d [4];
  logic [SRAM_DATA_WIDTH-1:0] wdata_q [2];
  logic [SRAM_DATA_WIDTH-1:0] wdata_d [2];
  logic [1:0]                 cur_q, cur_d;
  logic                       err_q, err_d;
  logic                       tag_q [TagDepth];
  logic                       tag_d [TagDepth];
  logic [TAG_DEPTH_BITS-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]            cnt_q, cnt_d;

  logic                       rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [SRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [SRAM_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [3:0]                 ack_q, ack_d;
  logic [1:0]                 vld_q, vld_d;
  logic [SRAM_DATA_WIDTH-1:0] rdata_q [2];
  logic [SRAM_DATA_WIDTH-1:0] rdata_d [2];

`ifdef SRAM_ARB_RR_EN
  logic                       rr_q, rr_d;
`endif

  logic       full, push, pop, gnt_found;
  logic [1:0] gnt_ch, idx;
  logic [3:0] elig;

  assign req_in     = {shi_wr_req, shi_rd_req, upd_wr_req, upd_rd_req};
  assign addr_in[0] = upd_rd_addr;
  assign addr_in[1] = upd_wr_addr;
  assign addr_in[2] = shi_rd_addr;
  assign addr_in[3] = shi_wr_addr;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cur_d     = cur_q;
    err_d     = err_q;
    tag_d     = tag_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rd_req_d  = 1'b0;
    wr_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ack_d     = '0;
    vld_d     = '0;
    rdata_d   = rdata_q;
    push      = 1'b0;
    pop       = 1'b0;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    idx       = '0;
`ifdef SRAM_ARB_RR_EN
    rr_d      = rr_q;
`endif

    // Capture; a pulse on a channel that is already pending is a protocol error.
    for (int i = 0; i < 4; i++) begin
      if (req_in[i]) begin
        if (pend_q[i]) begin
          err_d = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          addr_d[i] = addr_in[i];
        end
      end
    end
    if (upd_wr_req && !pend_q[1]) wdata_d[0] = upd_wr_data;
    if (shi_wr_req && !pend_q[3]) wdata_d[1] = shi_wr_data;

    // Same-cycle captures are eligible so an idle arbiter grants on the next edge.
    full = (cnt_q == CntFull);
    elig = pend_d;
    if (full) begin
      elig[0] = 1'b0;
      elig[2] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
      idx = 2'(i) + {rr_q, 1'b0};
`else
      idx = 2'(i);
`endif
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = idx;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          cur_d = gnt_ch;
`ifdef SRAM_ARB_RR_EN
          rr_d  = ~gnt_ch[1];
`endif
          if (!gnt_ch[0]) begin
            rd_req_d  = 1'b1;
            rd_addr_d = addr_d[gnt_ch];
            push      = 1'b1;
            state_d   = StWaitRd;
          end else begin
            wr_req_d  = 1'b1;
            wr_addr_d = addr_d[gnt_ch];
            wr_data_d = wdata_d[gnt_ch[1]];
            state_d   = StWaitWr;
          end
        end
      end
      StWaitRd: begin
        if (sram_rd_ack) begin
          pend_d[cur_q] = 1'b0;
          ack_d[cur_q]  = 1'b1;
          state_d       = StIdle;
        end
      end
      StWaitWr: begin
        if (sram_wr_ack) begin
          pend_d[cur_q] = 1'b0;
          ack_d[cur_q]  = 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (push) begin
      tag_d[wptr_q] = gnt_ch[1];
      wptr_d        = wptr_q + PtrOne;
    end

    // Read data with no outstanding tag has no owner: drop it and flag.
    if (sram_rd_vld) begin
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        pop                     = 1'b1;
        vld_d[tag_q[rptr_q]]    = 1'b1;
        rdata_d[tag_q[rptr_q]]  = sram_rd_data;
        rptr_d                  = rptr_q + PtrOne;
      end
    end
    cnt_d = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      pend_q    <= '0;
      cur_q     <= '0;
      err_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ack_q     <= '0;
      vld_q     <= '0;
      for (int i = 0; i < 4; i++) addr_q[i] <= '0;
      for (int i = 0; i < 2; i++) begin
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
      for (int i = 0; i < TagDepth; i++) tag_q[i] <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      cur_q     <= cur_d;
      err_q     <= err_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ack_q     <= ack_d;
      vld_q     <= vld_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      tag_q     <= tag_d;
`ifdef SRAM_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign sram_rd_req  = rd_req_q;
  assign sram_rd_addr = rd_addr_q;
  assign sram_wr_req  = wr_req_q;
  assign sram_wr_addr = wr_addr_q;
  assign sram_wr_data = wr_data_q;
  assign upd_rd_ack   = ack_q[0];
  assign upd_wr_ack   = ack_q[1];
  assign shi_rd_ack   = ack_q[2];
  assign shi_wr_ack   = ack_q[3];
  assign upd_rd_vld   = vld_q[0];
  assign shi_rd_vld   = vld_q[1];
  assign upd_rd_data  = rdata_q[0];
  assign shi_rd_data  = rdata_q[1];
  assign arb_err      = err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, directed corner sequences, then random traffic
// checked against a queue-based owner/ack model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_rd_req, upd_wr_req, shi_rd_req, shi_wr_req;
  logic [18:0] upd_rd_addr, upd_wr_addr, shi_rd_addr, shi_wr_addr;
  logic [71:0] upd_wr_data, shi_wr_data;
  logic        upd_rd_ack, upd_wr_ack, shi_rd_ack, shi_wr_ack;
  logic [71:0] upd_rd_data, shi_rd_data;
  logic        upd_rd_vld, shi_rd_vld;
  logic        sram_rd_req, sram_wr_req;
  logic [18:0] sram_rd_addr, sram_wr_addr;
  logic [71:0] sram_wr_data, sram_rd_data;
  logic        sram_rd_ack, sram_wr_ack, sram_rd_vld;
  logic        arb_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .reset(reset),
    .upd_rd_req(upd_rd_req), .upd_rd_addr(upd_rd_addr), .upd_rd_ack(upd_rd_ack),
    .upd_rd_data(upd_rd_data), .upd_rd_vld(upd_rd_vld),
    .upd_wr_req(upd_wr_req), .upd_wr_addr(upd_wr_addr), .upd_wr_data(upd_wr_data),
    .upd_wr_ack(upd_wr_ack),
    .shi_rd_req(shi_rd_req), .shi_rd_addr(shi_rd_addr), .shi_rd_ack(shi_rd_ack),
    .shi_rd_data(shi_rd_data), .shi_rd_vld(shi_rd_vld),
    .shi_wr_req(shi_wr_req), .shi_wr_addr(shi_wr_addr), .shi_wr_data(shi_wr_data),
    .shi_wr_ack(shi_wr_ack),
    .sram_rd_req(sram_rd_req), .sram_rd_addr(sram_rd_addr), .sram_rd_ack(sram_rd_ack),
    .sram_rd_data(sram_rd_data), .sram_rd_vld(sram_rd_vld),
    .sram_wr_req(sram_wr_req), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .sram_wr_ack(sram_wr_ack), .arb_err(arb_err)
  );

  typedef struct {
    int          ch;
    logic [18:0] addr;
    logic [71:0] wdata;
    logic [71:0] rdata;
    logic [1:0]  exp_req;   // {wr, rd}
    logic [18:0] exp_addr;
    logic [71:0] exp_wdata;
    logic [3:0]  exp_ack;   // {shi_wr, shi_rd, upd_wr, upd_rd}
    logic [1:0]  exp_vld;   // {shi, upd}
    logic [71:0] exp_rdata;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic v);
    case (ch)
      0:       upd_rd_req = v;
      1:       upd_wr_req = v;
      2:       shi_rd_req = v;
      default: shi_wr_req = v;
    endcase
  endtask

  task automatic set_addr(input int ch, input logic [18:0] a, input logic [71:0] d);
    case (ch)
      0: upd_rd_addr = a;
      1: begin upd_wr_addr = a; upd_wr_data = d; end
      2: shi_rd_addr = a;
      default: begin shi_wr_addr = a; shi_wr_data = d; end
    endcase
  endtask

  // Ends in the cycle after the sampling edge, i.e. the earliest grant cycle.
  task automatic pulse(input int ch, input logic [18:0] a, input logic [71:0] d);
    set_addr(ch, a, d);
    set_req(ch, 1'b1);
    tick();
    set_req(ch, 1'b0);
  endtask

  task automatic wait_grant(input bit wr, input string name);
    int n = 0;
    while (!(wr ? sram_wr_req : sram_rd_req) && n < 20) begin
      tick();
      n++;
    end
    chk(name, 72'(wr ? sram_wr_req : sram_rd_req), 72'(1));
  endtask

  // SRAM accepts two cycles after the request; ends in the client-ack cycle.
  task automatic sram_ack(input bit wr);
    tick();
    tick();
    if (wr) sram_wr_ack = 1'b1; else sram_rd_ack = 1'b1;
    tick();
    sram_wr_ack = 1'b0;
    sram_rd_ack = 1'b0;
  endtask

  task automatic run_txn(input int ch, input logic [18:0] a, input logic [71:0] d,
                         input string name);
    pulse(ch, a, d);
    wait_grant(ch[0], name);
    sram_ack(ch[0]);
  endtask

  task automatic ret(input logic [71:0] d);
    sram_rd_vld  = 1'b1;
    sram_rd_data = d;
    tick();
    sram_rd_vld  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic random_phase();
    bit          outst   [4];
    bit          granted [4];
    logic [18:0] caddr   [4];
    logic [71:0] cwdata  [4];
    bit          owner_q [$];
    int          rd_dly = -1, wr_dly = -1, rd_ch = 0, wr_ch = 0, ch;
    logic [3:0]  exp_ack = '0;
    bit          exp_vld = 1'b0, exp_owner = 1'b0;
    logic [71:0] exp_d = '0;
    logic [1:0]  exp_v;
    logic [3:0]  left;
    for (int i = 0; i < 4; i++) begin
      outst[i]   = 1'b0;
      granted[i] = 1'b0;
      caddr[i]   = '0;
      cwdata[i]  = '0;
    end
    for (int cyc = 0; cyc < 2300; cyc++) begin
      tick();
      chk("rnd ack", 72'({shi_wr_ack, shi_rd_ack, upd_wr_ack, upd_rd_ack}), 72'(exp_ack));
      for (int i = 0; i < 4; i++) if (exp_ack[i]) begin outst[i] = 1'b0; granted[i] = 1'b0; end
      exp_ack = '0;
      exp_v = exp_vld ? (exp_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd vld", 72'({shi_rd_vld, upd_rd_vld}), 72'(exp_v));
      if (exp_vld) chk("rnd rdata", exp_owner ? shi_rd_data : upd_rd_data, exp_d);
      exp_vld = 1'b0;
      if (sram_rd_req) begin
        ch = sram_rd_addr[18] ? 2 : 0;
        chk("rnd rd grant legit", 72'(outst[ch] && !granted[ch]), 72'(1));
        chk("rnd rd addr", 72'(sram_rd_addr), 72'(caddr[ch]));
        granted[ch] = 1'b1;
        rd_ch       = ch;
        rd_dly      = $urandom_range(0, 3);
        owner_q.push_back(ch == 2);
      end
      if (sram_wr_req) begin
        ch = sram_wr_addr[18] ? 3 : 1;
        chk("rnd wr grant legit", 72'(outst[ch] && !granted[ch]), 72'(1));
        chk("rnd wr addr", 72'(sram_wr_addr), 72'(caddr[ch]));
        chk("rnd wr data", sram_wr_data, cwdata[ch]);
        granted[ch] = 1'b1;
        wr_ch       = ch;
        wr_dly      = $urandom_range(0, 3);
      end
      chk("rnd arb_err", 72'(arb_err), 72'(0));
      sram_rd_ack = 1'b0;
      sram_wr_ack = 1'b0;
      if (rd_dly == 0) begin sram_rd_ack = 1'b1; exp_ack[rd_ch] = 1'b1; rd_dly = -1; end
      else if (rd_dly > 0) rd_dly--;
      if (wr_dly == 0) begin sram_wr_ack = 1'b1; exp_ack[wr_ch] = 1'b1; wr_dly = -1; end
      else if (wr_dly > 0) wr_dly--;
      sram_rd_vld = 1'b0;
      if (owner_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        sram_rd_vld  = 1'b1;
        sram_rd_data = 72'({$urandom, $urandom, $urandom});
        exp_vld      = 1'b1;
        exp_owner    = owner_q.pop_front();
        exp_d        = sram_rd_data;
      end
      for (int c = 0; c < 4; c++) begin
        set_req(c, 1'b0);
        if (cyc < 2000 && !outst[c] && $urandom_range(0, 3) == 0) begin
          outst[c]  = 1'b1;
          caddr[c]  = {c[1], 18'($urandom)};
          cwdata[c] = 72'({$urandom, $urandom, $urandom});
          set_addr(c, caddr[c], cwdata[c]);
          set_req(c, 1'b1);
        end
      end
    end
    set_req(0, 1'b0); set_req(1, 1'b0); set_req(2, 1'b0); set_req(3, 1'b0);
    left = {outst[3], outst[2], outst[1], outst[0]};
    chk("rnd drained channels", 72'(left), 72'(0));
    chk("rnd drained tags", 72'(owner_q.size()), 72'(0));
  endtask

  initial begin
    vec_t vecs[4];
    vec_t v;
    vecs[0] = '{2, 19'h00005, 72'h0, 72'hAB, 2'b01, 19'h00005, 72'h0, 4'b0100, 2'b10, 72'hAB};
    vecs[1] = '{0, 19'h00010, 72'h0, 72'h111, 2'b01, 19'h00010, 72'h0, 4'b0001, 2'b01,
                72'h111};
    vecs[2] = '{1, 19'h7FFFF, 72'hFFFFFFFFFFFFFFFFFF, 72'h0, 2'b10, 19'h7FFFF,
                72'hFFFFFFFFFFFFFFFFFF, 4'b0010, 2'b00, 72'h0};
    vecs[3] = '{3, 19'h40000, 72'h123, 72'h0, 2'b10, 19'h40000, 72'h123, 4'b1000, 2'b00,
                72'h0};

    reset = 1'b0;
    upd_rd_req = 0; upd_wr_req = 0; shi_rd_req = 0; shi_wr_req = 0;
    upd_rd_addr = '0; upd_wr_addr = '0; shi_rd_addr = '0; shi_wr_addr = '0;
    upd_wr_data = '0; shi_wr_data = '0;
    sram_rd_ack = 0; sram_wr_ack = 0; sram_rd_vld = 0; sram_rd_data = '0;
    #3;
    chk("reset reqs", 72'({sram_rd_req, sram_wr_req}), 72'(0));
    chk("reset acks", 72'({upd_rd_ack, upd_wr_ack, shi_rd_ack, shi_wr_ack}), 72'(0));
    chk("reset vlds", 72'({upd_rd_vld, shi_rd_vld, arb_err}), 72'(0));
    chk("reset addr", 72'({sram_rd_addr, sram_wr_addr}), 72'(0));
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      pulse(v.ch, v.addr, v.wdata);
      chk("vec grant", 72'({sram_wr_req, sram_rd_req}), 72'(v.exp_req));
      chk("vec addr", 72'(v.ch[0] ? sram_wr_addr : sram_rd_addr), 72'(v.exp_addr));
      if (v.ch[0]) chk("vec wdata", sram_wr_data, v.exp_wdata);
      tick();
      chk("vec req one cycle", 72'({sram_wr_req, sram_rd_req}), 72'(0));
      tick();
      if (v.ch[0]) sram_wr_ack = 1'b1; else sram_rd_ack = 1'b1;
      tick();
      sram_wr_ack = 1'b0;
      sram_rd_ack = 1'b0;
      chk("vec ack", 72'({shi_wr_ack, shi_rd_ack, upd_wr_ack, upd_rd_ack}), 72'(v.exp_ack));
      if (!v.ch[0]) begin
        tick(); tick(); tick();
        ret(v.rdata);
        chk("vec vld", 72'({shi_rd_vld, upd_rd_vld}), 72'(v.exp_vld));
        chk("vec rdata", v.ch[1] ? shi_rd_data : upd_rd_data, v.exp_rdata);
      end
      tick();
    end

    // Interleaved owners: data must follow request order.
    run_txn(0, 19'h00010, 72'h0, "ilv U grant");
    run_txn(2, 19'h00020, 72'h0, "ilv S grant");
    tick();
    ret(72'h111);
    chk("ilv first owner", 72'({shi_rd_vld, upd_rd_vld}), 72'(2'b01));
    chk("ilv first data", upd_rd_data, 72'h111);
    ret(72'h222);
    chk("ilv second owner", 72'({shi_rd_vld, upd_rd_vld}), 72'(2'b10));
    chk("ilv second data", shi_rd_data, 72'h222);
    chk("ilv U data kept", upd_rd_data, 72'h111);

    // Contention; the preceding U grant leaves any round-robin pointer at S.
    tick();
    run_txn(1, 19'h00100, 72'h1, "cont pre grant");
    tick();
    upd_wr_addr = 19'h00200; upd_wr_data = 72'hBEEF; shi_rd_addr = 19'h40300;
    upd_wr_req = 1'b1; shi_rd_req = 1'b1;
    tick();
    upd_wr_req = 1'b0; shi_rd_req = 1'b0;
`ifdef SRAM_ARB_RR_EN
    chk("cont first", 72'({sram_wr_req, sram_rd_req}), 72'(2'b01));
    chk("cont first addr", 72'(sram_rd_addr), 72'(19'h40300));
    sram_ack(1'b0);
    chk("cont S ack", 72'(shi_rd_ack), 72'(1));
    tick();
    chk("cont second", 72'({sram_wr_req, sram_rd_req}), 72'(2'b10));
    chk("cont second addr", 72'(sram_wr_addr), 72'(19'h00200));
    sram_ack(1'b1);
    chk("cont U ack", 72'(upd_wr_ack), 72'(1));
`else
    chk("cont first", 72'({sram_wr_req, sram_rd_req}), 72'(2'b10));
    chk("cont first data", sram_wr_data, 72'hBEEF);
    sram_ack(1'b1);
    chk("cont U ack", 72'({upd_wr_ack, sram_rd_req}), 72'(2'b10));
    tick();
    chk("cont second", 72'({sram_wr_req, sram_rd_req}), 72'(2'b01));
    chk("cont second addr", 72'(sram_rd_addr), 72'(19'h40300));
    sram_ack(1'b0);
    chk("cont S ack", 72'(shi_rd_ack), 72'(1));
`endif
    tick();
    ret(72'h777);
    chk("cont S data", 72'({shi_rd_vld, shi_rd_data}), {1'b1, 72'h777});

    // Tag FIFO full: eight unanswered reads block a ninth but not a write.
    for (int i = 0; i < 8; i++) run_txn(0, 19'(32'h100 + i), 72'h0, "full fill grant");
    tick();
    upd_rd_addr = 19'h001FF; shi_wr_addr = 19'h40001; shi_wr_data = 72'hCAFE;
    upd_rd_req = 1'b1; shi_wr_req = 1'b1;
    tick();
    upd_rd_req = 1'b0; shi_wr_req = 1'b0;
    chk("full write wins", 72'({sram_wr_req, sram_rd_req}), 72'(2'b10));
    sram_ack(1'b1);
    chk("full write ack", 72'(shi_wr_ack), 72'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full read held", 72'(sram_rd_req), 72'(0));
    end
    ret(72'h900);
    chk("full pop data", 72'({upd_rd_vld, upd_rd_data}), {1'b1, 72'h900});
    wait_grant(1'b0, "full ninth grant");
    chk("full ninth addr", 72'(sram_rd_addr), 72'(19'h001FF));
    sram_ack(1'b0);
    chk("full ninth ack", 72'(upd_rd_ack), 72'(1));
    for (int i = 0; i < 8; i++) begin
      ret(72'(32'hA00 + i));
      chk("full drain", 72'({upd_rd_vld, upd_rd_data}), {1'b1, 72'(32'hA00 + i)});
    end
    chk("full no err", 72'(arb_err), 72'(0));

    // Orphan read data.
    do_reset();
    ret(72'h5A5);
    chk("orphan err", 72'(arb_err), 72'(1));
    chk("orphan no vld", 72'({shi_rd_vld, upd_rd_vld}), 72'(0));
    tick(); tick();
    chk("orphan err sticky", 72'(arb_err), 72'(1));
    do_reset();
    chk("err cleared by reset", 72'(arb_err), 72'(0));

    // Duplicate request while pending.
    pulse(3, 19'h40002, 72'h42);
    chk("dup first grant", 72'(sram_wr_req), 72'(1));
    pulse(3, 19'h40002, 72'h42);
    chk("dup err", 72'(arb_err), 72'(1));
    chk("dup no regrant", 72'(sram_wr_req), 72'(0));
    sram_wr_ack = 1'b1;
    tick();
    sram_wr_ack = 1'b0;
    chk("dup single ack", 72'(shi_wr_ack), 72'(1));
    tick();
    chk("dup no extra", 72'({shi_wr_ack, sram_wr_req, sram_rd_req}), 72'(0));
    chk("dup err held", 72'(arb_err), 72'(1));

    // Reset during WAIT_RD clears outputs without a clock edge.
    do_reset();
    pulse(0, 19'h00033, 72'h0);
    chk("mid grant", 72'(sram_rd_req), 72'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("mid async clear", 72'({sram_rd_req, sram_rd_addr, upd_rd_ack, arb_err}), 72'(0));
    tick();
    reset = 1'b1;
    tick();
    run_txn(0, 19'h00044, 72'h0, "mid recover grant");
    chk("mid recover ack", 72'(upd_rd_ack), 72'(1));
    ret(72'h55);
    chk("mid recover data", 72'({upd_rd_vld, upd_rd_data}), {1'b1, 72'h55});

    do_reset();
    random_phase();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
